// File: rtl/mgmt_arbiter.sv
// Round-robin arbiter sharing one mgmt bus between two requesters, one transaction
// in flight at a time, with a per-phase watchdog that fakes an error response.
module mgmt_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned CNT_W    = 8,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        sys_clk,
    input  logic        sys_setn,

    input  logic        s0_req,
    input  logic [31:0] s0_adr,
    input  logic        s0_rwn,
    input  logic [1:0]  s0_wen,
    input  logic [31:0] s0_txd,
    output logic        s0_ack,
    output logic        s0_rxe,

    input  logic        s1_req,
    input  logic [31:0] s1_adr,
    input  logic        s1_rwn,
    input  logic [1:0]  s1_wen,
    input  logic [31:0] s1_txd,
    output logic        s1_ack,
    output logic        s1_rxe,

    output logic [31:0] s_rxd,

    output logic        mgmt_req,
    output logic [31:0] mgmt_adr,
    output logic        mgmt_rwn,
    output logic [1:0]  mgmt_wen,
    output logic [31:0] mgmt_txd,
    input  logic        mgmt_ack,
    input  logic        mgmt_rxe,
    input  logic [31:0] mgmt_rxd,

    output logic        busy,
    output logic        err,
    output logic        err_id
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam bit              WDOG_EN  = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             gnt_q, gnt_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             err_id_q, err_id_d;

    logic        sel_rwn;
    logic [31:0] sel_adr;
    logic [31:0] sel_txd;
    logic [1:0]  sel_wen;
    logic        tmo;
    logic        ack;
    logic        rxe;

    always_comb begin
        sel_rwn = gnt_q ? s1_rwn : s0_rwn;
        sel_adr = gnt_q ? s1_adr : s0_adr;
        sel_txd = gnt_q ? s1_txd : s0_txd;
        sel_wen = gnt_q ? s1_wen : s0_wen;
    end

    // A real completion always beats the watchdog in the same cycle.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        err_id_d = err_id_q;
        tmo      = 1'b0;
        ack      = 1'b0;
        rxe      = 1'b0;
        case (state_q)
            IDLE: begin
                if (s0_req || s1_req) begin
                    gnt_d   = (s0_req && s1_req) ? ~last_q : s1_req;
                    state_d = ADDR;
                    cnt_d   = '0;
                end
            end
            ADDR: begin
                tmo = WDOG_EN && !mgmt_ack && (cnt_q == CNT_LAST);
                ack = mgmt_ack || tmo;
                rxe = sel_rwn && ((mgmt_ack && mgmt_rxe) || tmo);
                if (ack) begin
                    last_d  = gnt_q;
                    state_d = (sel_rwn && !rxe) ? DATA : IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                tmo = WDOG_EN && !mgmt_rxe && (cnt_q == CNT_LAST);
                rxe = mgmt_rxe || tmo;
                if (rxe) begin
                    last_d  = gnt_q;
                    state_d = IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (tmo) begin
            err_d    = 1'b1;
            err_id_d = gnt_q;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_setn) begin
        if (!sys_setn) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            err_id_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            err_id_q <= err_id_d;
        end
    end

    // Downstream bus is parked at a read of address 0 while idle.
    assign mgmt_req = (state_q == ADDR);
    assign mgmt_adr = (state_q == IDLE) ? 32'h0 : sel_adr;
    assign mgmt_rwn = (state_q == IDLE) ? 1'b1  : sel_rwn;
    assign mgmt_wen = (state_q == IDLE) ? 2'b00 : sel_wen;
    assign mgmt_txd = (state_q == IDLE) ? 32'h0 : sel_txd;

    assign s0_ack = ack & ~gnt_q;
    assign s1_ack = ack &  gnt_q;
    assign s0_rxe = rxe & ~gnt_q;
    assign s1_rxe = rxe &  gnt_q;
    assign s_rxd  = tmo ? ERR_DATA : mgmt_rxd;

    assign busy   = (state_q != IDLE);
    assign err    = err_q;
    assign err_id = err_id_q;

endmodule

// File: tb/tb_mgmt_arbiter.sv
// Self-checking bench for mgmt_arbiter: directed transactions plus a transaction-level
// reference model compared against the outputs on every falling clock edge.
module tb_mgmt_arbiter;

    localparam int          TMO  = 4;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        sys_clk, sys_setn;
    logic        s0_req, s0_rwn, s0_ack, s0_rxe;
    logic [31:0] s0_adr, s0_txd;
    logic [1:0]  s0_wen;
    logic        s1_req, s1_rwn, s1_ack, s1_rxe;
    logic [31:0] s1_adr, s1_txd;
    logic [1:0]  s1_wen;
    logic [31:0] s_rxd;
    logic        mgmt_req, mgmt_rwn, mgmt_ack, mgmt_rxe;
    logic [31:0] mgmt_adr, mgmt_txd, mgmt_rxd;
    logic [1:0]  mgmt_wen;
    logic        busy, err, err_id;

    int errors = 0;
    int checks = 0;

    mgmt_arbiter #(.TIMEOUT(TMO), .CNT_W(8), .ERR_DATA(ERRD)) dut (
        .sys_clk(sys_clk), .sys_setn(sys_setn),
        .s0_req(s0_req), .s0_adr(s0_adr), .s0_rwn(s0_rwn), .s0_wen(s0_wen), .s0_txd(s0_txd),
        .s0_ack(s0_ack), .s0_rxe(s0_rxe),
        .s1_req(s1_req), .s1_adr(s1_adr), .s1_rwn(s1_rwn), .s1_wen(s1_wen), .s1_txd(s1_txd),
        .s1_ack(s1_ack), .s1_rxe(s1_rxe),
        .s_rxd(s_rxd),
        .mgmt_req(mgmt_req), .mgmt_adr(mgmt_adr), .mgmt_rwn(mgmt_rwn), .mgmt_wen(mgmt_wen),
        .mgmt_txd(mgmt_txd), .mgmt_ack(mgmt_ack), .mgmt_rxe(mgmt_rxe), .mgmt_rxd(mgmt_rxd),
        .busy(busy), .err(err), .err_id(err_id)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit port, input logic req, input logic rwn,
                                 input logic [31:0] adr, input logic [1:0] wen, input logic [31:0] txd);
        if (port) begin
            s1_req = req; s1_rwn = rwn; s1_adr = adr; s1_wen = wen; s1_txd = txd;
        end else begin
            s0_req = req; s0_rwn = rwn; s0_adr = adr; s0_wen = wen; s0_txd = txd;
        end
    endtask

    task automatic setReq(input bit port, input logic v);
        if (port) s1_req = v;
        else      s0_req = v;
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Reference model: which port owns the bus, which phase, how long it has waited.
    int owner    = -1;
    bit inData   = 1'b0;
    int waited   = 0;
    bit lastWin  = 1'b1;
    bit errPend  = 1'b0;
    bit errPort  = 1'b0;

    always @(negedge sys_clk) begin : model
        bit          busyE, reqE, rd, complete, timedOut, ackE, rxeE;
        logic [31:0] adrE, txdE;
        logic [1:0]  wenE;
        if (!sys_setn) begin
            owner = -1; inData = 1'b0; waited = 0; lastWin = 1'b1; errPend = 1'b0; errPort = 1'b0;
        end
        busyE    = (owner >= 0);
        reqE     = busyE && !inData;
        rd       = (owner == 1) ? s1_rwn : s0_rwn;
        adrE     = !busyE ? 32'h0 : ((owner == 1) ? s1_adr : s0_adr);
        txdE     = !busyE ? 32'h0 : ((owner == 1) ? s1_txd : s0_txd);
        wenE     = !busyE ? 2'b00 : ((owner == 1) ? s1_wen : s0_wen);
        complete = busyE && (inData ? mgmt_rxe : mgmt_ack);
        timedOut = busyE && !complete && (waited == TMO - 1);
        ackE     = reqE && (mgmt_ack || timedOut);
        rxeE     = inData ? (mgmt_rxe || timedOut)
                          : (reqE && rd && ((mgmt_ack && mgmt_rxe) || timedOut));

        checkOutput("model busy", busy, busyE);
        checkOutput("model mgmt_req", mgmt_req, reqE);
        checkOutput("model mgmt_adr", mgmt_adr, adrE);
        checkOutput("model mgmt_rwn", mgmt_rwn, busyE ? rd : 1'b1);
        checkOutput("model mgmt_wen", mgmt_wen, wenE);
        checkOutput("model mgmt_txd", mgmt_txd, txdE);
        checkOutput("model s0_ack", s0_ack, ackE && owner == 0);
        checkOutput("model s1_ack", s1_ack, ackE && owner == 1);
        checkOutput("model s0_rxe", s0_rxe, rxeE && owner == 0);
        checkOutput("model s1_rxe", s1_rxe, rxeE && owner == 1);
        checkOutput("model err", err, errPend);
        checkOutput("model err_id", err_id, errPort);
        if (rxeE) checkOutput("model s_rxd", s_rxd, timedOut ? ERRD : mgmt_rxd);

        if (sys_setn) begin
            errPend = timedOut;
            if (timedOut) errPort = (owner == 1);
            if (!busyE) begin
                if (s0_req || s1_req) begin
                    owner  = (s0_req && s1_req) ? (lastWin ? 0 : 1) : (s1_req ? 1 : 0);
                    inData = 1'b0;
                    waited = 0;
                end
            end else if (complete || timedOut) begin
                lastWin = (owner == 1);
                if (!inData && !timedOut && rd && !mgmt_rxe) begin
                    inData = 1'b1;
                    waited = 0;
                end else begin
                    owner  = -1;
                    inData = 1'b0;
                end
            end else begin
                waited++;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "[TB] time limit");
    end

    int order[4] = '{0, 1, 0, 1};

    initial begin
        sys_setn = 1'b0;
        applyStimulus(0, 0, 1, 32'h0, 2'b00, 32'h0);
        applyStimulus(1, 0, 1, 32'h0, 2'b00, 32'h0);
        mgmt_ack = 1'b0; mgmt_rxe = 1'b0; mgmt_rxd = 32'h0;
        tick(); tick();
        sys_setn = 1'b1;
        #2;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset mgmt_req", mgmt_req, 0);
        checkOutput("reset err", err, 0);
        checkOutput("reset idle rwn", mgmt_rwn, 1);

        // Uncontended write, ack two cycles after mgmt_req rises.
        tick(); applyStimulus(0, 1, 0, 32'h0000_0100, 2'b11, 32'h1234_5678); #2;
        checkOutput("wr idle no req", mgmt_req, 0);
        tick(); #2;
        checkOutput("wr req latency", mgmt_req, 1);
        checkOutput("wr adr", mgmt_adr, 32'h0000_0100);
        checkOutput("wr wen", mgmt_wen, 2'b11);
        checkOutput("wr txd", mgmt_txd, 32'h1234_5678);
        checkOutput("wr rwn", mgmt_rwn, 0);
        tick(); #2;
        tick(); mgmt_ack = 1'b1; #2;
        checkOutput("wr s0_ack", s0_ack, 1);
        checkOutput("wr s1_ack", s1_ack, 0);
        tick(); mgmt_ack = 1'b0; setReq(0, 0); #2;
        checkOutput("wr busy after", busy, 0);
        checkOutput("wr idle adr", mgmt_adr, 32'h0);

        // Split read on port 1, stray ack in DATA, rxe three cycles after ack.
        tick(); applyStimulus(1, 1, 1, 32'h0000_0040, 2'b00, 32'h0); #2;
        tick(); mgmt_ack = 1'b1; #2;
        checkOutput("rd1 s1_ack", s1_ack, 1);
        checkOutput("rd1 s1_rxe early", s1_rxe, 0);
        tick(); mgmt_ack = 1'b0; setReq(1, 0); #2;
        checkOutput("rd1 data req low", mgmt_req, 0);
        checkOutput("rd1 data busy", busy, 1);
        tick(); mgmt_ack = 1'b1; #2;
        checkOutput("rd1 stray ack", s1_ack, 0);
        tick(); mgmt_ack = 1'b0; mgmt_rxe = 1'b1; mgmt_rxd = 32'hCAFE_0001; #2;
        checkOutput("rd1 s1_rxe", s1_rxe, 1);
        checkOutput("rd1 s_rxd", s_rxd, 32'hCAFE_0001);
        checkOutput("rd1 s0_rxe", s0_rxe, 0);
        tick(); mgmt_rxe = 1'b0; #2;
        checkOutput("rd1 busy after", busy, 0);

        // Read with ack and rxe together: no DATA phase.
        tick(); applyStimulus(0, 1, 1, 32'h0000_0080, 2'b00, 32'h0); #2;
        tick(); mgmt_ack = 1'b1; mgmt_rxe = 1'b1; mgmt_rxd = 32'h5A5A_0033; #2;
        checkOutput("rd0 s0_ack", s0_ack, 1);
        checkOutput("rd0 s0_rxe", s0_rxe, 1);
        checkOutput("rd0 s_rxd", s_rxd, 32'h5A5A_0033);
        tick(); mgmt_ack = 1'b0; mgmt_rxe = 1'b0; setReq(0, 0); #2;
        checkOutput("rd0 no data phase", busy, 0);

        // Contention from reset: grants must alternate starting with port 0.
        tick(); sys_setn = 1'b0; #2;
        checkOutput("reset2 busy", busy, 0);
        tick(); sys_setn = 1'b1;
        applyStimulus(0, 1, 0, 32'h0000_1000, 2'b11, 32'h0000_00A0);
        applyStimulus(1, 1, 0, 32'h0000_2000, 2'b11, 32'h0000_00B0);
        #2;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i > 0) setReq(order[i-1][0], 1);
            mgmt_ack = 1'b1; #2;
            checkOutput($sformatf("cont grant %0d", i), {31'b0, s1_ack}, order[i]);
            checkOutput($sformatf("cont one ack %0d", i), s0_ack ^ s1_ack, 1);
            tick(); mgmt_ack = 1'b0; setReq(order[i][0], 0);
            if (i == 3) begin
                setReq(0, 0);
                setReq(1, 0);
            end
            #2;
        end
        tick(); setReq(0, 1); setReq(1, 1); #2;
        tick(); mgmt_ack = 1'b1; #2;
        checkOutput("rr after p1 -> p0", s0_ack, 1);
        tick(); mgmt_ack = 1'b0; setReq(0, 0); setReq(1, 0); #2;
        tick(); setReq(0, 1); setReq(1, 1); #2;
        tick(); mgmt_ack = 1'b1; #2;
        checkOutput("rr after p0 -> p1", s1_ack, 1);
        checkOutput("rr p1 adr", mgmt_adr, 32'h0000_2000);
        tick(); mgmt_ack = 1'b0; setReq(0, 0); setReq(1, 0); #2;

        // Watchdog in ADDR: read never acked.
        tick(); applyStimulus(0, 1, 1, 32'h0000_0200, 2'b00, 32'h0); #2;
        for (int c = 0; c < 3; c++) begin
            tick(); #2;
            checkOutput($sformatf("tmo wait %0d", c), s0_ack, 0);
        end
        tick(); #2;
        checkOutput("tmo s0_ack", s0_ack, 1);
        checkOutput("tmo s0_rxe", s0_rxe, 1);
        checkOutput("tmo s_rxd", s_rxd, 32'hDEAD_BEEF);
        checkOutput("tmo err not yet", err, 0);
        tick(); setReq(0, 0); mgmt_ack = 1'b1; #2;
        checkOutput("tmo err pulse", err, 1);
        checkOutput("tmo err_id", err_id, 0);
        checkOutput("tmo late ack", s0_ack, 0);
        tick(); mgmt_ack = 1'b0; #2;
        checkOutput("tmo err one cycle", err, 0);

        // Watchdog in DATA on port 1.
        tick(); applyStimulus(1, 1, 1, 32'h0000_0300, 2'b00, 32'h0); #2;
        tick(); mgmt_ack = 1'b1; #2;
        tick(); mgmt_ack = 1'b0; setReq(1, 0); #2;
        tick(); #2;
        tick(); #2;
        tick(); #2;
        checkOutput("dtmo s1_rxe", s1_rxe, 1);
        checkOutput("dtmo s_rxd", s_rxd, 32'hDEAD_BEEF);
        tick(); #2;
        checkOutput("dtmo err", err, 1);
        checkOutput("dtmo err_id", err_id, 1);

        // Ack on the timeout cycle wins: no error.
        tick(); applyStimulus(0, 1, 0, 32'h0000_0400, 2'b01, 32'h0000_0077); #2;
        tick(); #2;
        tick(); #2;
        tick(); #2;
        tick(); mgmt_ack = 1'b1; #2;
        checkOutput("race s0_ack", s0_ack, 1);
        tick(); mgmt_ack = 1'b0; setReq(0, 0); #2;
        checkOutput("race no err", err, 0);

        // Reset while a read sits in DATA.
        tick(); applyStimulus(0, 1, 1, 32'h0000_0500, 2'b00, 32'h0); #2;
        tick(); mgmt_ack = 1'b1; #2;
        tick(); mgmt_ack = 1'b0; setReq(0, 0); #2;
        checkOutput("rst data busy", busy, 1);
        tick(); sys_setn = 1'b0; mgmt_rxe = 1'b1; mgmt_rxd = 32'h0000_0011; #1;
        checkOutput("rst busy", busy, 0);
        checkOutput("rst s0_rxe", s0_rxe, 0);
        checkOutput("rst s0_ack", s0_ack, 0);
        checkOutput("rst mgmt_req", mgmt_req, 0);
        tick(); sys_setn = 1'b1;
        applyStimulus(0, 1, 0, 32'h0000_0600, 2'b11, 32'h0000_0066);
        applyStimulus(1, 1, 0, 32'h0000_0700, 2'b11, 32'h0000_0077);
        #2;
        checkOutput("rst late rxe dropped", s0_rxe, 0);
        tick(); mgmt_rxe = 1'b0; mgmt_ack = 1'b1; #2;
        checkOutput("rst p0 wins", s0_ack, 1);
        checkOutput("rst p0 adr", mgmt_adr, 32'h0000_0600);
        tick(); mgmt_ack = 1'b0; setReq(0, 0); setReq(1, 0); #2;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
